// File: rtl/decode_stage.sv
// decode_stage -- instruction-decode pipeline stage.
//
// Decodes the IF/ID instruction, reads the register file, detects load-use
// hazards against its own ID/EX register and launches a valid-tagged ID/EX
// bundle toward execute.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   ifIdValid                   IF/ID instruction is real (not a bubble)
//   programCounterIn            PC+4 of the IF/ID instruction
//   instruction                 MIPS word: op[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0]
//   writeRegister/Data, regWrite  write-back port into the register file
//   flush                       squash the instruction in decode
//   hold                        execute cannot accept; freeze ID/EX
//   idExValid                   ID/EX bundle is a real instruction
//   writeBackControl[1:0]       {regWrite, memToReg}
//   memAccessControl[2:0]       {branch, memRead, memWrite}
//   calculationControl[3:0]     {regDst, aluOp[1:0], aluSrc}
//   programCounterOut           latched programCounterIn
//   readData1/2                 rs / rt operands
//   immediateOperand            sign-extended imm[15:0]
//   rs, rt, rd                  latched register fields
//   pcWrite, ifIdWrite          combinational; 0 stalls fetch and IF/ID
//
// Build option: DECODE_WRITE_BYPASS_EN -- same-cycle write-back is forwarded
// to the register-file read ports.

module decode_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int PC_WIDTH       = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ifIdValid,
   input  logic [PC_WIDTH-1:0]       programCounterIn,
   input  logic [31:0]               instruction,
   input  logic [REG_ADDR_WIDTH-1:0] writeRegister,
   input  logic [DATA_WIDTH-1:0]     writeData,
   input  logic                      regWrite,
   input  logic                      flush,
   input  logic                      hold,
   output logic                      idExValid,
   output logic [1:0]                writeBackControl,
   output logic [2:0]                memAccessControl,
   output logic [3:0]                calculationControl,
   output logic [PC_WIDTH-1:0]       programCounterOut,
   output logic [DATA_WIDTH-1:0]     readData1,
   output logic [DATA_WIDTH-1:0]     readData2,
   output logic [DATA_WIDTH-1:0]     immediateOperand,
   output logic [REG_ADDR_WIDTH-1:0] rs,
   output logic [REG_ADDR_WIDTH-1:0] rt,
   output logic [REG_ADDR_WIDTH-1:0] rd,
   output logic                      pcWrite,
   output logic                      ifIdWrite
);

   localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   logic [DATA_WIDTH-1:0]     regFile [NUM_REGS];

   logic [5:0]                opcode;
   logic [REG_ADDR_WIDTH-1:0] currentRs;
   logic [REG_ADDR_WIDTH-1:0] currentRt;
   logic [REG_ADDR_WIDTH-1:0] currentRd;
   logic [DATA_WIDTH-1:0]     rsValue;
   logic [DATA_WIDTH-1:0]     rtValue;
   logic [DATA_WIDTH-1:0]     immediateNext;
   logic [1:0]                writeBackNext;
   logic [2:0]                memAccessNext;
   logic [3:0]                calculationNext;
   logic                      loadUse;

   assign opcode        = instruction[31:26];
   assign currentRs     = instruction[21 +: REG_ADDR_WIDTH];
   assign currentRt     = instruction[16 +: REG_ADDR_WIDTH];
   assign currentRd     = instruction[11 +: REG_ADDR_WIDTH];
   assign immediateNext = DATA_WIDTH'($signed(instruction[15:0]));

   // Control opcode decoder
   always_comb begin
      writeBackNext   = '0;
      memAccessNext   = '0;
      calculationNext = '0;
      case (opcode)
         OP_RTYPE: begin
            writeBackNext   = 2'b10;
            calculationNext = 4'b1100;
         end
         OP_LW: begin
            writeBackNext   = 2'b11;
            memAccessNext   = 3'b010;
            calculationNext = 4'b0001;
         end
         OP_SW: begin
            memAccessNext   = 3'b001;
            calculationNext = 4'b0001;
         end
         OP_BEQ: begin
            memAccessNext   = 3'b100;
            calculationNext = 4'b0010;
         end
         OP_ADDI: begin
            writeBackNext   = 2'b10;
            calculationNext = 4'b0001;
         end
         default: begin
         end
      endcase
   end

   // Register file: entry 0 is never written and always reads 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regFile[i] <= '0;
         end
      end else if (regWrite && (writeRegister != '0)) begin
         regFile[writeRegister] <= writeData;
      end
   end

   always_comb begin
      rsValue = (currentRs == '0) ? '0 : regFile[currentRs];
      rtValue = (currentRt == '0) ? '0 : regFile[currentRt];
`ifdef DECODE_WRITE_BYPASS_EN
      if (regWrite && (writeRegister != '0) && (writeRegister == currentRs)) begin
         rsValue = writeData;
      end
      if (regWrite && (writeRegister != '0) && (writeRegister == currentRt)) begin
         rtValue = writeData;
      end
`endif
   end

   // A load in ID/EX whose destination is a source of the decoding instruction
   assign loadUse = ifIdValid & idExValid & memAccessControl[1] & (rt != '0) &
                    ((rt == currentRs) | (rt == currentRt));

   // flush overrides hold/stall so fetch can redirect
   assign pcWrite   = flush | ~(hold | loadUse);
   assign ifIdWrite = pcWrite;

   // ID/EX register; priority reset > flush > hold > loadUse > normal.
   // Bubbles clear only valid and controls; the data fields keep their value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idExValid          <= 1'b0;
         writeBackControl   <= '0;
         memAccessControl   <= '0;
         calculationControl <= '0;
         programCounterOut  <= '0;
         readData1          <= '0;
         readData2          <= '0;
         immediateOperand   <= '0;
         rs                 <= '0;
         rt                 <= '0;
         rd                 <= '0;
      end else if (flush || (!hold && loadUse)) begin
         idExValid          <= 1'b0;
         writeBackControl   <= '0;
         memAccessControl   <= '0;
         calculationControl <= '0;
      end else if (!hold) begin
         idExValid          <= ifIdValid;
         writeBackControl   <= ifIdValid ? writeBackNext   : '0;
         memAccessControl   <= ifIdValid ? memAccessNext   : '0;
         calculationControl <= ifIdValid ? calculationNext : '0;
         programCounterOut  <= programCounterIn;
         readData1          <= rsValue;
         readData2          <= rtValue;
         immediateOperand   <= immediateNext;
         rs                 <= currentRs;
         rt                 <= currentRt;
         rd                 <= currentRd;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- self-checking bench for decode_stage (default widths).
// Directed scenarios followed by randomized traffic, checked against a
// behavioural pipeline model. Honours DECODE_WRITE_BYPASS_EN like the DUT.

module tb_decode_stage;

   logic        clk;
   logic        reset;
   logic        ifIdValid;
   logic [31:0] programCounterIn;
   logic [31:0] instruction;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;
   logic        regWrite;
   logic        flush;
   logic        hold;
   logic        idExValid;
   logic [1:0]  writeBackControl;
   logic [2:0]  memAccessControl;
   logic [3:0]  calculationControl;
   logic [31:0] programCounterOut;
   logic [31:0] readData1;
   logic [31:0] readData2;
   logic [31:0] immediateOperand;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic        pcWrite;
   logic        ifIdWrite;

   int checkCount = 0;
   int errorCount = 0;

   decode_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .ifIdValid(ifIdValid),
      .programCounterIn(programCounterIn), .instruction(instruction),
      .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
      .flush(flush), .hold(hold), .idExValid(idExValid),
      .writeBackControl(writeBackControl), .memAccessControl(memAccessControl),
      .calculationControl(calculationControl), .programCounterOut(programCounterOut),
      .readData1(readData1), .readData2(readData2), .immediateOperand(immediateOperand),
      .rs(rs), .rt(rt), .rd(rd), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   logic [31:0] refRegs [32];
   logic        mValid;
   logic [8:0]  mCtrl;      // {writeBack, memAccess, calculation}
   logic [31:0] mPc, mRd1, mRd2, mImm;
   logic [4:0]  mRs, mRt, mRd;
   logic        expWrite;

   task automatic checkValue(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Control truth table of the MIPS opcode decoder
   function automatic logic [8:0] refControl(input logic [5:0] op);
      case (op)
         6'h00:   return {2'b10, 3'b000, 4'b1100};
         6'h23:   return {2'b11, 3'b010, 4'b0001};
         6'h2B:   return {2'b00, 3'b001, 4'b0001};
         6'h04:   return {2'b00, 3'b100, 4'b0010};
         6'h08:   return {2'b10, 3'b000, 4'b0001};
         default: return 9'd0;
      endcase
   endfunction

   function automatic logic [31:0] refRead(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
`ifdef DECODE_WRITE_BYPASS_EN
      if (regWrite && writeRegister == r) return writeData;
`endif
      return refRegs[r];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
      mValid = 1'b0; mCtrl = '0; mPc = '0; mRd1 = '0; mRd2 = '0; mImm = '0;
      mRs = '0; mRt = '0; mRd = '0;
   endtask

   function automatic logic refStall();
      logic [4:0] srcRs, srcRt;
      srcRs = instruction[25:21];
      srcRt = instruction[20:16];
      return ifIdValid && mValid && mCtrl[5] && mRt != 0 && (mRt == srcRs || mRt == srcRt);
   endfunction

   task automatic modelEdge();
      logic stall;
      stall = refStall();
      if (flush || (!hold && stall)) begin
         mValid = 1'b0;
         mCtrl  = '0;
      end else if (!hold) begin
         mValid = ifIdValid;
         mCtrl  = ifIdValid ? refControl(instruction[31:26]) : 9'd0;
         mPc    = programCounterIn;
         mRd1   = refRead(instruction[25:21]);
         mRd2   = refRead(instruction[20:16]);
         mImm   = {{16{instruction[15]}}, instruction[15:0]};
         mRs    = instruction[25:21];
         mRt    = instruction[20:16];
         mRd    = instruction[15:11];
      end
      if (regWrite && writeRegister != 0) refRegs[writeRegister] = writeData;
   endtask

   task automatic checkOutputs(input string tag);
      checkValue({tag, ".valid"}, idExValid, mValid);
      checkValue({tag, ".ctrl"}, {writeBackControl, memAccessControl, calculationControl}, mCtrl);
      if (mValid) begin
         checkValue({tag, ".pc"}, programCounterOut, mPc);
         checkValue({tag, ".rd1"}, readData1, mRd1);
         checkValue({tag, ".rd2"}, readData2, mRd2);
         checkValue({tag, ".imm"}, immediateOperand, mImm);
         checkValue({tag, ".fields"}, {rs, rt, rd}, {mRs, mRt, mRd});
      end
   endtask

   // Called just after a negedge with inputs already driven.
   task automatic doCycle(input string tag);
      #1;
      expWrite = flush || !(hold || refStall());
      checkValue({tag, ".pcWrite"}, pcWrite, expWrite);
      checkValue({tag, ".ifIdWrite"}, ifIdWrite, expWrite);
      modelEdge();
      @(posedge clk);
      #1;
      checkOutputs(tag);
      @(negedge clk);
   endtask

   task automatic present(input logic [31:0] instr, input logic valid);
      instruction      = instr;
      ifIdValid        = valid;
      programCounterIn = programCounterIn + 32'd4;
   endtask

   logic [31:0] savedPc;
   logic [4:0]  savedRt;
   logic [5:0]  opList [6];

   initial begin
      opList = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
      reset = 1'b1; ifIdValid = 0; programCounterIn = 32'h100; instruction = 0;
      writeRegister = 0; writeData = 0; regWrite = 0; flush = 0; hold = 0;
      modelReset();
      @(negedge clk);
      #1;
      checkOutputs("reset");
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkValue("resetPcWrite", pcWrite, 1'b1);
      checkValue("resetIfIdWrite", ifIdWrite, 1'b1);

      // lw r3, 4(r2)
      present(32'h8C430004, 1'b1);
      doCycle("lw");
      checkValue("lwValid", idExValid, 1'b1);
      checkValue("lwMemRead", memAccessControl[1], 1'b1);
      checkValue("lwRt", rt, 5'd3);
      checkValue("lwImm", immediateOperand, 32'h4);

      // add r4, r3, r5 -> one-cycle load-use stall
      present(32'h00652020, 1'b1);
      #1;
      checkValue("stallPcWrite", pcWrite, 1'b0);
      checkValue("stallIfIdWrite", ifIdWrite, 1'b0);
      doCycle("stall");
      checkValue("stallBubble", idExValid, 1'b0);
      doCycle("addLaunch");
      checkValue("addValid", idExValid, 1'b1);
      checkValue("addRd", rd, 5'd4);

      // r7 = 0x11111111, then same-cycle write of 0xDEADBEEF while reading rs=7
      regWrite = 1; writeRegister = 5'd7; writeData = 32'h11111111;
      present(32'h00000000, 1'b1);
      doCycle("preload");
      writeData = 32'hDEADBEEF;
      present(32'h00E00000, 1'b1);
      doCycle("bypass");
`ifdef DECODE_WRITE_BYPASS_EN
      checkValue("bypassRead", readData1, 32'hDEADBEEF);
`else
      checkValue("bypassRead", readData1, 32'h11111111);
`endif
      regWrite = 0;
      present(32'h00E00000, 1'b1);
      doCycle("afterWrite");
      checkValue("afterWriteRead", readData1, 32'hDEADBEEF);

      // hold for three cycles with new instructions presented
      present(32'h8C430004, 1'b1);
      doCycle("holdSetup");
      savedPc = programCounterOut;
      savedRt = rt;
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         present(32'h20A6FFFF, 1'b1);
         #1;
         checkValue("holdPcWrite", pcWrite, 1'b0);
         doCycle("hold");
         checkValue("holdPcKept", programCounterOut, savedPc);
         checkValue("holdRtKept", rt, savedRt);
         checkValue("holdValidKept", idExValid, 1'b1);
      end

      // flush together with hold
      flush = 1;
      #1;
      checkValue("flushPcWrite", pcWrite, 1'b1);
      doCycle("flushHold");
      checkValue("flushValid", idExValid, 1'b0);
      checkValue("flushCtrl", {writeBackControl, memAccessControl, calculationControl}, 9'd0);
      flush = 0; hold = 0;

      // write to r0 is discarded; same-cycle and later reads of r0 return 0
      regWrite = 1; writeRegister = 5'd0; writeData = 32'h12345678;
      present(32'h00000000, 1'b1);
      doCycle("r0Write");
      checkValue("r0SameCycle", readData1, 32'd0);
      regWrite = 0;
      present(32'h00000000, 1'b1);
      doCycle("r0Read");
      checkValue("r0Read", readData1, 32'd0);

      // reset asserted during a pending stall and hold
      present(32'h8C430004, 1'b1);
      doCycle("rstSetup");
      present(32'h00652020, 1'b1);
      hold = 1;
      #1;
      reset = 1;
      modelReset();
      #1;
      checkOutputs("midReset");
      hold = 0;
      @(negedge clk);
      reset = 0;
      present(32'h00E00000, 1'b1);
      doCycle("postReset");
      checkValue("postResetR7", readData1, 32'd0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] w;
         w = $urandom;
         w[31:26] = opList[$urandom_range(0, 5)];
         w[25:21] = 5'($urandom_range(0, 7));
         w[20:16] = 5'($urandom_range(0, 7));
         instruction      = w;
         ifIdValid        = ($urandom_range(0, 9) != 0);
         programCounterIn = $urandom;
         flush            = ($urandom_range(0, 9) == 0);
         hold             = ($urandom_range(0, 6) == 0);
         regWrite         = $urandom_range(0, 1) == 1;
         writeRegister    = 5'($urandom_range(0, 7));
         writeData        = $urandom;
         doCycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
